// File: rtl/pwm_capture.sv
// PWM input-capture unit.
// Synchronises an asynchronous PWM line, then measures its period (rise to
// rise) and high time (rise to fall) in CLK cycles. One result is reported per
// complete period. A programmable timeout flags a line that has stopped
// toggling. Enable and IRQ-trigger behaviour match the companion PWM timer.
module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,  // synchroniser depth, minimum 2
    parameter int unsigned CNT_W       = 32  // counter and result width
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             GO_EN,
    input  logic             PWM_IN,
    input  logic [CNT_W-1:0] TIMEOUT_CNT,
    output logic [CNT_W-1:0] PERIOD_CNT,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic             VALID,
    output logic             OVF,
    output logic             STUCK,
    output logic             STUCK_LVL,
    output logic             IRQ_TRG
);

    typedef enum logic [1:0] {
        ST_IDLE,  // disabled, counter frozen
        ST_ARM,   // enabled, waiting for the first rise
        ST_HIGH,  // measuring the high phase
        ST_LOW    // measuring the low phase, next rise closes the period
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Input path
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic                   pwm_d_q;
    logic                   rise;
    logic                   fall;

    // Enable edge detection
    logic                   go_en_d1_q;
    logic                   go_arm;

    // Measurement state
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   cnt_at_max;
    logic                   timeout_hit;
    logic [CNT_W-1:0]       high_lat_q;

    // Registered outputs
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic                   valid_q;
    logic                   ovf_q;
    logic                   stuck_q;
    logic                   stuck_lvl_q;
    logic                   stuck_d1_q;

    // Shift PWM_IN through the synchroniser and keep one extra delayed copy for edge detection.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample their inputs from before the edge, independent of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
            pwm_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_q;
    assign fall  = ~pwm_s & pwm_d_q;

    // Remember last cycle's GO_EN so only a genuine 0->1 transition re-arms.
    // NOTE: this flop resets to 1, so a GO_EN already high when reset releases
    // is not mistaken for a rising edge; the block waits in IDLE for a real one.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            go_en_d1_q <= 1'b1;
        end else begin
            go_en_d1_q <= GO_EN;
        end
    end

    assign go_arm = GO_EN & ~go_en_d1_q;

    // Saturating increment and timeout compare; any edge in the compare cycle suppresses the timeout.
    assign cnt_at_max  = (cnt_q == CNT_MAX);
    assign cnt_inc     = cnt_at_max ? CNT_MAX : cnt_q + CNT_ONE;
    assign timeout_hit = (TIMEOUT_CNT != '0) && (cnt_q == TIMEOUT_CNT) && !(rise | fall);

    // Capture state machine: counts phases, publishes results and flags a stuck line.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_lat_q  <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
            stuck_d1_q  <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            stuck_d1_q <= stuck_q;

            if (!GO_EN) begin
                state_q <= ST_IDLE;
            end else if (go_arm) begin
                // Edges seen in the arming cycle are deliberately ignored.
                state_q <= ST_ARM;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                stuck_q <= 1'b0;
            end else if (state_q != ST_IDLE) begin
                // NOTE: the plain count below is the default; a later
                // non-blocking assignment to the same flop in this block wins.
                cnt_q <= cnt_inc;
                if (cnt_at_max) begin
                    ovf_q <= 1'b1;
                end

                if (timeout_hit) begin
                    stuck_q     <= 1'b1;
                    stuck_lvl_q <= pwm_s;
                    cnt_q       <= '0;
                    state_q     <= ST_ARM;
                end else begin
                    case (state_q)
                        ST_ARM: begin
                            // First rise starts a measurement; the partial period before it is dropped.
                            if (rise) begin
                                cnt_q   <= CNT_ONE;
                                state_q <= ST_HIGH;
                            end
                        end
                        ST_HIGH: begin
                            if (fall) begin
                                high_lat_q <= cnt_q;
                                state_q    <= ST_LOW;
                            end
                        end
                        ST_LOW: begin
                            // The closing rise is also cycle 1 of the next period.
                            if (rise) begin
                                period_q <= cnt_q;
                                high_q   <= high_lat_q;
                                valid_q  <= 1'b1;
                                cnt_q    <= CNT_ONE;
                                ovf_q    <= 1'b0;
                                stuck_q  <= 1'b0;
                                state_q  <= ST_HIGH;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign PERIOD_CNT = period_q;
    assign HIGH_CNT   = high_q;
    assign VALID      = valid_q;
    assign OVF        = ovf_q;
    assign STUCK      = stuck_q;
    assign STUCK_LVL  = stuck_lvl_q;
    assign IRQ_TRG    = valid_q | (stuck_q & ~stuck_d1_q);

endmodule
